// File: rtl/regfile_pkg.sv
// rtl/regfile_pkg.sv - shared defaults, init-mode encodings and FSM states for the register file
package regfile_pkg;

    localparam int XLEN_DEF   = 32;
    localparam int NREG_DEF   = 32;

    localparam int INIT_ZERO  = 0;
    localparam int INIT_INDEX = 1;

    typedef enum logic {
        ST_INIT,
        ST_RUN
    } state_e;

endpackage

// File: rtl/rf_scoreboard.sv
// rtl/rf_scoreboard.sv - pending-load busy vector with set/clear priority and sticky protocol error
module rf_scoreboard
    import regfile_pkg::*;
#(
    parameter int  NREG   = NREG_DEF,
    parameter int  BYPASS = 1,
    localparam int AW     = $clog2(NREG)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          run,
    input  logic          wa_en,
    input  logic [AW-1:0] wa_addr,
    input  logic          alloc_en,
    input  logic [AW-1:0] alloc_addr,
    input  logic          wb_en,
    input  logic [AW-1:0] wb_addr,
    input  logic [AW-1:0] rs1_addr,
    input  logic [AW-1:0] rs2_addr,
    output logic          rs1_busy,
    output logic          rs2_busy,
    output logic          err
);

    logic [NREG-1:0] busy_q, busy_d;
    logic            err_q, err_d;
    logic            wa_v, alloc_v, wb_v;

    assign wa_v    = run && wa_en    && (wa_addr    != '0);
    assign alloc_v = run && alloc_en && (alloc_addr != '0);
    assign wb_v    = run && wb_en    && (wb_addr    != '0);

    // Clear before set so a same-cycle alloc to the returning register wins (new load).
    always_comb begin
        busy_d = busy_q;
        if (wb_v) begin
            busy_d[wb_addr] = 1'b0;
        end
        if (alloc_v) begin
            busy_d[alloc_addr] = 1'b1;
        end
        busy_d[0] = 1'b0;

        err_d = err_q;
        if (alloc_v && busy_q[alloc_addr] && !(wb_v && (wb_addr == alloc_addr))) begin
            err_d = 1'b1;
        end
        if (wb_v && !busy_q[wb_addr]) begin
            err_d = 1'b1;
        end
        if (wa_v && busy_q[wa_addr]) begin
            err_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            busy_q <= '0;
            err_q  <= 1'b0;
        end else begin
            busy_q <= busy_d;
            err_q  <= err_d;
        end
    end

    assign rs1_busy = run && busy_q[rs1_addr] && !((BYPASS != 0) && wb_v && (wb_addr == rs1_addr));
    assign rs2_busy = run && busy_q[rs2_addr] && !((BYPASS != 0) && wb_v && (wb_addr == rs2_addr));
    assign err      = err_q;

endmodule

// File: rtl/regfile_scoreboard.sv
// rtl/regfile_scoreboard.sv - 2R/2W integer register file with init sequencer, bypass and load scoreboard
module regfile_scoreboard
    import regfile_pkg::*;
#(
    parameter int  XLEN      = XLEN_DEF,
    parameter int  NREG      = NREG_DEF,
    parameter int  INIT_MODE = INIT_INDEX,
    parameter int  BYPASS    = 1,
    localparam int AW        = $clog2(NREG)
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [AW-1:0]   rs1_addr,
    input  logic [AW-1:0]   rs2_addr,
    output logic [XLEN-1:0] rs1_data,
    output logic [XLEN-1:0] rs2_data,
    output logic            rs1_busy,
    output logic            rs2_busy,
    input  logic            wa_en,
    input  logic [AW-1:0]   wa_addr,
    input  logic [XLEN-1:0] wa_data,
    input  logic            alloc_en,
    input  logic [AW-1:0]   alloc_addr,
    input  logic            wb_en,
    input  logic [AW-1:0]   wb_addr,
    input  logic [XLEN-1:0] wb_data,
    output logic            ready,
    output logic            err
);

    state_e          state_q, state_d;
    logic [AW-1:0]   cnt_q, cnt_d;
    logic [XLEN-1:0] regs_q [NREG];
    logic [XLEN-1:0] regs_d [NREG];
    logic            run, wa_v, wb_v;
    logic [AW-1:0]   rd_addr [2];
    logic [XLEN-1:0] rd_data [2];

    assign run  = (state_q == ST_RUN);
    assign wa_v = run && wa_en && (wa_addr != '0);
    assign wb_v = run && wb_en && (wb_addr != '0);

    // wa is applied after wb so the younger ALU result wins a same-address collision.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        regs_d  = regs_q;
        case (state_q)
            ST_INIT: begin
                regs_d[cnt_q] = (INIT_MODE == INIT_INDEX) ? XLEN'(cnt_q) : '0;
                cnt_d         = cnt_q + AW'(1);
                if (cnt_q == AW'(NREG - 1)) begin
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                if (wb_v) begin
                    regs_d[wb_addr] = wb_data;
                end
                if (wa_v) begin
                    regs_d[wa_addr] = wa_data;
                end
            end
            default: state_d = ST_INIT;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_INIT;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_ff @(posedge clk) begin
        regs_q <= regs_d;
    end

    assign rd_addr[0] = rs1_addr;
    assign rd_addr[1] = rs2_addr;

    always_comb begin
        for (int p = 0; p < 2; p++) begin
            rd_data[p] = regs_q[rd_addr[p]];
            if (rd_addr[p] == '0) begin
                rd_data[p] = '0;
            end else if (BYPASS != 0) begin
                if (wa_v && (wa_addr == rd_addr[p])) begin
                    rd_data[p] = wa_data;
                end else if (wb_v && (wb_addr == rd_addr[p])) begin
                    rd_data[p] = wb_data;
                end
            end
        end
    end

    assign rs1_data = rd_data[0];
    assign rs2_data = rd_data[1];
    assign ready    = run;

    rf_scoreboard #(
        .NREG   (NREG),
        .BYPASS (BYPASS)
    ) u_sb (
        .clk        (clk),
        .reset      (reset),
        .run        (run),
        .wa_en      (wa_en),
        .wa_addr    (wa_addr),
        .alloc_en   (alloc_en),
        .alloc_addr (alloc_addr),
        .wb_en      (wb_en),
        .wb_addr    (wb_addr),
        .rs1_addr   (rs1_addr),
        .rs2_addr   (rs2_addr),
        .rs1_busy   (rs1_busy),
        .rs2_busy   (rs2_busy),
        .err        (err)
    );

endmodule
